mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port, synchronous-read backing memory between the core's instruction-fetch port and data port, so the core can run from a unified RAM. Sits between `core` and the memory: the core side matches the core's `imem_*`/`dmem_*` interface exactly, and the memory side is a single buffered-input RAM port with a one-cycle read latency. Both ports requesting in the same cycle is a conflict: the data access wins, the fetch is latched and replayed one cycle later, and `imem_wait` stalls the core for that cycle. The block also holds delivered read data stable across stalls and counts conflicts.

## Interface
- Parameters: none.
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- imem_address  in  32  fetch address.
- imem_enable  in  1  fetch request.
- imem_data  out  32  fetched word.
- imem_wait  out  1  fetch not yet delivered; the core stalls while high.
- dmem_address  in  32  data address.
- dmem_enable  in  1  data port enable.
- dmem_write_data  in  32  store data.
- dmem_write_enable  in  1  store request.
- dmem_write_mode  in  3  store size/mode; passed through to memory.
- dmem_read_enable  in  1  load request.
- dmem_read_mode  in  3  load size/mode; passed through to memory.
- dmem_read_data  out  32  loaded word.
- dmem_wait  out  1  tied 0: a data access is never delayed.
- mem_address, mem_write_data  out  32  backing memory address and write data.
- mem_enable, mem_write_enable, mem_read_enable  out  1  backing memory controls.
- mem_write_mode, mem_read_mode  out  3  backing memory modes.
- mem_read_data  in  32  read data; valid in the cycle after a read is issued.
- conflict_count  out  32  number of same-cycle fetch/data conflicts since reset.

## Operation
- Request definitions:
  - Data request: `dreq = dmem_enable && (dmem_read_enable || dmem_write_enable)`.
  - Fetch request: `ireq = imem_enable`.
- State machine: IDLE, REPLAY.
- IDLE:
  - `dreq` only: forward all `dmem_*` signals to the `mem_*` outputs combinationally.
  - `ireq` only: drive `mem_address = imem_address`, read enable 1, `mem_read_mode = 3'b010`, write enable 0.
  - Both requested: forward the data request, latch `imem_address` into `pend_addr`, increment `conflict_count` (wraps at 2^32), go to REPLAY.
  - Neither requested: `mem_enable = 0`.
- REPLAY:
  - Issue a word read of `pend_addr`, assert `imem_wait`, return to IDLE.
  - `ireq`/`dreq` asserted in REPLAY are ignored; the core is stalled, so they do not occur legally.
- Read return tracking:
  - Register `last_op` records which port the previous cycle's memory read belonged to: NONE, I or D. A write records NONE.
  - `last_op == I`: `imem_data = mem_read_data`, and capture it into `ihold`.
  - `last_op == D`: `dmem_read_data = mem_read_data`, and capture it into `dhold`.
  - Otherwise each output shows its hold register. Data is therefore stable until the next read for that port returns.
- Conflict data path: in the REPLAY cycle, the data load issued in the conflict cycle returns. It is captured into `dhold`, and `dmem_read_data` must present `dhold` in the following cycle, when the core's pipeline re-enables.
- Unused `mem_*` outputs: `mem_write_data` and `mem_write_mode` are 0 when not forwarding a data store.

## Timing
- Reset values:
  - State IDLE; `last_op` NONE.
  - `pend_addr`, `ihold`, `dhold` = 0; `conflict_count` = 0.
  - `imem_data`, `dmem_read_data` = 0; `imem_wait` = 0; `mem_enable` = 0.
- Latency, no conflict: a request in cycle N returns data in N+1; `imem_wait` stays 0.
- Latency, conflict in cycle N:
  - Data load returns in N+1 and is held into N+2.
  - Fetch is issued in N+1; `imem_wait` = 1 in N+1 only; fetch data is visible in N+2.
- `imem_wait` is a Moore output (high only in REPLAY) with no combinational path from inputs.
- Store-plus-fetch conflict: same flow; `dhold` is not updated.
- Reset asserted in any cycle, including REPLAY: the next cycle is in the reset state, and the pending fetch is discarded without issue.
- `conflict_count` increments exactly once per conflict cycle.

## Test plan
- Fetch only at address 0x10, memory word 0x00500093 → `mem_read_mode` 3'b010; `imem_data` 0x00500093 next cycle; `imem_wait` never 1.
- Load at 0x100 (returns 0xDEADBEEF) together with fetch at 0x14 (returns 0x00100113) → memory sees 0x100 then 0x14; `imem_wait` high exactly one cycle; in N+2 `imem_data` 0x00100113 and `dmem_read_data` 0xDEADBEEF; `conflict_count` 1.
- Store 0x12345678, write mode 3'b010, at 0x200 together with fetch at 0x18 → write forwarded in N, read of 0x18 in N+1; `dmem_read_data` keeps its prior value.
- Idle for 5 cycles after a fetch returning 0xCAFEF00D → `imem_data` holds 0xCAFEF00D; `mem_enable` 0 throughout.
- Reset asserted during REPLAY → next cycle: `imem_wait` 0, `mem_enable` 0, `conflict_count` 0, no read issued for the pending address.
- `conflict_count` preloaded to 0xFFFFFFFF via force, then one conflict → value wraps to 0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port, synchronous-read memory between the
//            core's instruction-fetch and data ports. Data wins a same-cycle
//            conflict; the fetch is replayed one cycle later while imem_wait
//            stalls the core. Read data is held stable between returns.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  // instruction-fetch port
  input  logic [31:0] imem_address,
  input  logic        imem_enable,
  output logic [31:0] imem_data,
  output logic        imem_wait,
  // data port
  input  logic [31:0] dmem_address,
  input  logic        dmem_enable,
  input  logic [31:0] dmem_write_data,
  input  logic        dmem_write_enable,
  input  logic [2:0]  dmem_write_mode,
  input  logic        dmem_read_enable,
  input  logic [2:0]  dmem_read_mode,
  output logic [31:0] dmem_read_data,
  output logic        dmem_wait,
  // backing memory port
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_enable,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [2:0]  mem_write_mode,
  output logic [2:0]  mem_read_mode,
  input  logic [31:0] mem_read_data,
  // statistics
  output logic [31:0] conflict_count
);

  localparam logic [2:0] WORD_MODE = 3'b010;

  typedef enum logic [0:0] {IDLE = 1'b0, REPLAY = 1'b1} state_t;
  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_I = 2'd1, OP_D = 2'd2} op_t;

  state_t      state, next_state;
  op_t         last_op, next_op;
  logic [31:0] pend_addr;
  logic [31:0] ihold, dhold;
  logic        dreq, ireq, conflict;

  assign dreq      = dmem_enable && (dmem_read_enable || dmem_write_enable);
  assign ireq      = imem_enable;
  assign dmem_wait = 1'b0;
  // Moore stall: high exactly while the deferred fetch is being issued.
  assign imem_wait = (state == REPLAY);

  // State, pending fetch address, return tracking, hold registers, counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_op        <= OP_NONE;
      pend_addr      <= 32'd0;
      ihold          <= 32'd0;
      dhold          <= 32'd0;
      conflict_count <= 32'd0;
    end else begin
      state   <= next_state;
      last_op <= next_op;
      if (conflict) begin
        pend_addr      <= imem_address;
        conflict_count <= conflict_count + 32'd1;
      end
      if (last_op == OP_I) ihold <= mem_read_data;
      if (last_op == OP_D) dhold <= mem_read_data;
    end
  end

  // Next-state and memory-port steering; defaults leave the memory idle.
  always_comb begin
    next_state       = state;
    next_op          = OP_NONE;
    conflict         = 1'b0;
    mem_address      = 32'd0;
    mem_write_data   = 32'd0;
    mem_enable       = 1'b0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_mode   = 3'b000;
    mem_read_mode    = 3'b000;
    case (state)
      IDLE: begin
        if (dreq) begin
          mem_enable       = 1'b1;
          mem_address      = dmem_address;
          mem_write_enable = dmem_write_enable;
          mem_read_enable  = dmem_read_enable;
          mem_read_mode    = dmem_read_mode;
          if (dmem_write_enable) begin
            mem_write_data = dmem_write_data;
            mem_write_mode = dmem_write_mode;
          end
          // Only a pure load has data coming back for the data port.
          next_op = (dmem_read_enable && !dmem_write_enable) ? OP_D : OP_NONE;
          if (ireq) begin
            conflict   = 1'b1;
            next_state = REPLAY;
          end
        end else if (ireq) begin
          mem_enable      = 1'b1;
          mem_address     = imem_address;
          mem_read_enable = 1'b1;
          mem_read_mode   = WORD_MODE;
          next_op         = OP_I;
        end
      end
      REPLAY: begin
        // Core is stalled here, so any new requests are ignored.
        mem_enable      = 1'b1;
        mem_address     = pend_addr;
        mem_read_enable = 1'b1;
        mem_read_mode   = WORD_MODE;
        next_op         = OP_I;
        next_state      = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Nothing reaches memory while in reset, so a pending replay is dropped.
    if (!reset_n) begin
      mem_enable       = 1'b0;
      mem_write_enable = 1'b0;
      mem_read_enable  = 1'b0;
      conflict         = 1'b0;
    end
  end

  // Returning read data goes straight out; otherwise the last value is held.
  always_comb begin
    imem_data      = (last_op == OP_I) ? mem_read_data : ihold;
    dmem_read_data = (last_op == OP_D) ? mem_read_data : dhold;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed scoreboard bench for mem_arbiter. Stimulus pushes
//            cycle-tagged expectations; a monitor compares them each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_address;
  logic        imem_enable;
  logic [31:0] imem_data;
  logic        imem_wait;
  logic [31:0] dmem_address;
  logic        dmem_enable;
  logic [31:0] dmem_write_data;
  logic        dmem_write_enable;
  logic [2:0]  dmem_write_mode;
  logic        dmem_read_enable;
  logic [2:0]  dmem_read_mode;
  logic [31:0] dmem_read_data;
  logic        dmem_wait;
  logic [31:0] mem_address, mem_write_data;
  logic        mem_enable, mem_write_enable, mem_read_enable;
  logic [2:0]  mem_write_mode, mem_read_mode;
  logic [31:0] mem_read_data = 32'd0;
  logic [31:0] conflict_count;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .imem_address(imem_address), .imem_enable(imem_enable),
    .imem_data(imem_data), .imem_wait(imem_wait),
    .dmem_address(dmem_address), .dmem_enable(dmem_enable),
    .dmem_write_data(dmem_write_data), .dmem_write_enable(dmem_write_enable),
    .dmem_write_mode(dmem_write_mode), .dmem_read_enable(dmem_read_enable),
    .dmem_read_mode(dmem_read_mode), .dmem_read_data(dmem_read_data),
    .dmem_wait(dmem_wait),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_write_mode(mem_write_mode),
    .mem_read_mode(mem_read_mode), .mem_read_data(mem_read_data),
    .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  // Signal selectors for the scoreboard.
  localparam int S_IDATA = 0, S_DDATA = 1, S_IWAIT = 2, S_MEN = 3, S_MADDR = 4,
                 S_MREN = 5, S_MWEN = 6, S_MRMODE = 7, S_MWDATA = 8,
                 S_CNT = 9, S_MWMODE = 10, S_DWAIT = 11;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t e;

  // Backing memory model: one-cycle synchronous read.
  logic [31:0] mem [logic [31:0]];
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_write_enable) mem[mem_address] = mem_write_data;
      if (mem_read_enable)
        mem_read_data <= mem.exists(mem_address) ? mem[mem_address] : 32'd0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(int s);
    case (s)
      S_IDATA:  return imem_data;
      S_DDATA:  return dmem_read_data;
      S_IWAIT:  return {31'd0, imem_wait};
      S_MEN:    return {31'd0, mem_enable};
      S_MADDR:  return mem_address;
      S_MREN:   return {31'd0, mem_read_enable};
      S_MWEN:   return {31'd0, mem_write_enable};
      S_MRMODE: return {29'd0, mem_read_mode};
      S_MWDATA: return mem_write_data;
      S_CNT:    return conflict_count;
      S_MWMODE: return {29'd0, mem_write_mode};
      default:  return {31'd0, dmem_wait};
    endcase
  endfunction

  function automatic void expect_at(int c, int s, logic [31:0] v, string nm);
    exp_t x;
    x.cyc = c; x.sig = s; x.val = v; x.nm = nm;
    sb.push_back(x);
  endfunction

  // Monitor: compare every expectation due in the current cycle, mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: stale expectation for cycle %0d seen at %0d", e.nm, e.cyc, cyc);
      end else if (get_sig(e.sig) !== e.val) begin
        errors++;
        $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h", e.nm, cyc, get_sig(e.sig), e.val);
      end
    end
  end

  task automatic step(output int n);
    @(posedge clk);
    #2;
    n = cyc;
  endtask

  task automatic idle_inputs();
    imem_enable = 1'b0; imem_address = 32'd0;
    dmem_enable = 1'b0; dmem_address = 32'd0;
    dmem_write_enable = 1'b0; dmem_write_data = 32'd0; dmem_write_mode = 3'd0;
    dmem_read_enable = 1'b0; dmem_read_mode = 3'd0;
  endtask

  task automatic conflict_load(logic [31:0] daddr, logic [31:0] iaddr);
    dmem_enable = 1'b1; dmem_read_enable = 1'b1; dmem_read_mode = 3'b010;
    dmem_address = daddr;
    imem_enable = 1'b1; imem_address = iaddr;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    int budget;
    mem[32'h10]  = 32'h00500093;
    mem[32'h14]  = 32'h00100113;
    mem[32'h18]  = 32'h00200193;
    mem[32'h1C]  = 32'hCAFEF00D;
    mem[32'h20]  = 32'h11111111;
    mem[32'h24]  = 32'h22222222;
    mem[32'h100] = 32'hDEADBEEF;
    reset_n = 1'b0;
    idle_inputs();

    // Reset state.
    step(n);
    step(n);
    expect_at(n, S_IWAIT, 0, "rst_imem_wait");
    expect_at(n, S_MEN,   0, "rst_mem_enable");
    expect_at(n, S_IDATA, 0, "rst_imem_data");
    expect_at(n, S_DDATA, 0, "rst_dmem_read_data");
    expect_at(n, S_CNT,   0, "rst_conflict_count");
    expect_at(n, S_DWAIT, 0, "rst_dmem_wait");
    step(n);
    reset_n = 1'b1;

    // Fetch only.
    step(n);
    imem_enable = 1'b1; imem_address = 32'h10;
    expect_at(n, S_MEN,    1,     "f_mem_enable");
    expect_at(n, S_MADDR,  32'h10, "f_mem_address");
    expect_at(n, S_MREN,   1,     "f_mem_read_enable");
    expect_at(n, S_MRMODE, 2,     "f_mem_read_mode");
    expect_at(n, S_IWAIT,  0,     "f_imem_wait_n");
    step(n);
    idle_inputs();
    expect_at(n, S_IDATA, 32'h00500093, "f_imem_data");
    expect_at(n, S_IWAIT, 0, "f_imem_wait_n1");
    expect_at(n, S_MEN,   0, "f_mem_idle");

    // Load + fetch conflict.
    step(n);
    conflict_load(32'h100, 32'h14);
    expect_at(n, S_MADDR, 32'h100, "cl_addr_n");
    expect_at(n, S_MREN,  1, "cl_ren_n");
    expect_at(n, S_IWAIT, 0, "cl_wait_n");
    step(n);
    idle_inputs();
    expect_at(n, S_IWAIT,  1, "cl_wait_n1");
    expect_at(n, S_MADDR,  32'h14, "cl_addr_n1");
    expect_at(n, S_MRMODE, 2, "cl_mode_n1");
    expect_at(n, S_DDATA,  32'hDEADBEEF, "cl_ddata_n1");
    step(n);
    expect_at(n, S_IDATA, 32'h00100113, "cl_idata_n2");
    expect_at(n, S_DDATA, 32'hDEADBEEF, "cl_ddata_n2");
    expect_at(n, S_IWAIT, 0, "cl_wait_n2");
    expect_at(n, S_CNT,   1, "cl_count");

    // Store + fetch conflict.
    step(n);
    dmem_enable = 1'b1; dmem_write_enable = 1'b1; dmem_write_mode = 3'b010;
    dmem_write_data = 32'h12345678; dmem_address = 32'h200;
    imem_enable = 1'b1; imem_address = 32'h18;
    expect_at(n, S_MWEN,   1, "cs_wen_n");
    expect_at(n, S_MWDATA, 32'h12345678, "cs_wdata_n");
    expect_at(n, S_MADDR,  32'h200, "cs_addr_n");
    expect_at(n, S_MWMODE, 2, "cs_wmode_n");
    expect_at(n, S_MREN,   0, "cs_ren_n");
    step(n);
    idle_inputs();
    expect_at(n, S_IWAIT,  1, "cs_wait_n1");
    expect_at(n, S_MADDR,  32'h18, "cs_addr_n1");
    expect_at(n, S_MREN,   1, "cs_ren_n1");
    expect_at(n, S_MWEN,   0, "cs_wen_n1");
    expect_at(n, S_MWDATA, 0, "cs_wdata_n1");
    expect_at(n, S_DDATA,  32'hDEADBEEF, "cs_ddata_n1");
    step(n);
    expect_at(n, S_IDATA, 32'h00200193, "cs_idata_n2");
    expect_at(n, S_DDATA, 32'hDEADBEEF, "cs_ddata_n2");
    expect_at(n, S_CNT,   2, "cs_count");

    // Fetch then five idle cycles: data held, memory idle.
    step(n);
    imem_enable = 1'b1; imem_address = 32'h1C;
    step(n);
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      expect_at(n, S_IDATA, 32'hCAFEF00D, "hold_imem_data");
      expect_at(n, S_MEN,   0, "hold_mem_enable");
      if (k < 4) step(n);
    end

    // Reset asserted in the REPLAY cycle.
    step(n);
    conflict_load(32'h100, 32'h20);
    step(n);
    idle_inputs();
    reset_n = 1'b0;
    expect_at(n, S_IWAIT, 1, "rr_wait_replay");
    expect_at(n, S_MEN,   0, "rr_no_issue");
    step(n);
    reset_n = 1'b1;
    expect_at(n, S_IWAIT, 0, "rr_wait_after");
    expect_at(n, S_MEN,   0, "rr_men_after");
    expect_at(n, S_CNT,   0, "rr_count_after");
    expect_at(n, S_IDATA, 0, "rr_idata_after");

    // Counter wrap.
    step(n);
    force dut.conflict_count = 32'hFFFFFFFF;
    #1;
    release dut.conflict_count;
    conflict_load(32'h100, 32'h24);
    expect_at(n, S_CNT, 32'hFFFFFFFF, "wrap_preload");
    step(n);
    idle_inputs();
    expect_at(n, S_CNT, 0, "wrap_count");
    step(n);
    expect_at(n, S_IDATA, 32'h22222222, "wrap_idata");
    expect_at(n, S_DDATA, 32'hDEADBEEF, "wrap_ddata");

    // Drain the scoreboard within a bounded number of cycles.
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(posedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never checked", e.nm, e.cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
